// File: rtl/ssd_driver_if.sv
// ssd_driver_if
//   Bundles the debug-value input and the display/status outputs of the
//   seven-segment driver so the block can be connected with a single port.
//   master : the producer side (processor top / testbench) drives SSDInput
//            and observes the display pins and conversion status.
//   slave  : the ssd_driver itself.
//   Signals:
//     SSDInput  IN_W  unsigned binary value to display
//     Anode     4     digit enables, active-low, bit0 = least-significant digit
//     LED_out   7     segment cathodes {a,b,c,d,e,f,g}, active-low
//     bcd       16    committed BCD value {thousands,hundreds,tens,ones}
//     busy      1     high while a conversion is in progress
interface ssd_driver_if #(
  parameter int IN_W = 13
);
  logic [IN_W-1:0] SSDInput;
  logic [3:0]      Anode;
  logic [6:0]      LED_out;
  logic [15:0]     bcd;
  logic            busy;

  modport master (
    output SSDInput,
    input  Anode,
    input  LED_out,
    input  bcd,
    input  busy
  );

  modport slave (
    input  SSDInput,
    output Anode,
    output LED_out,
    output bcd,
    output busy
  );
endinterface

// File: rtl/ssd_driver.sv
// ssd_driver
//   Converts a 13-bit unsigned value to four BCD digits with a sequential
//   double-dabble engine (one shift-and-add-3 iteration per clock) and
//   time-multiplexes the digits onto a 4-digit common-anode display.
//   A conversion starts only when the input differs from the last converted
//   value (or on the first cycle after reset); the committed bcd register is
//   updated in a single cycle, so the display never shows a partial result.
//   Ports:
//     clk  board clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  ssd_driver_if.slave (SSDInput in; Anode, LED_out, bcd, busy out)
//   Parameters:
//     IN_W          input width (fixed at 13)
//     REFRESH_BITS  refresh counter width; each digit lit for 2^(REFRESH_BITS-2) cycles
//     BLANK_LZ      1 = blank leading-zero digits (digit 0 is never blanked)
module ssd_driver #(
  parameter int IN_W         = 13,
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input logic         clk,
  input logic         rst,
  ssd_driver_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'(IN_W - 1);

  // ---------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------
  logic [1:0]      state;
  logic            first;     // forces one conversion after reset even if input == last
  logic [IN_W-1:0] shift;     // remaining binary bits, consumed MSB first
  logic [IN_W-1:0] latched;   // value being converted, becomes 'last' on commit
  logic [IN_W-1:0] last;
  logic [15:0]     scratch;
  logic [3:0]      count;
  logic [15:0]     bcd_q;
  logic            busy_q;
  logic [15:0]     adj;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign adj = dabble_adjust(scratch);

  // NOTE: every register in a clocked block is assigned with <= so all
  // right-hand sides see the values from before the edge; a blocking = here
  // would let later statements observe half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      first   <= 1'b1;
      shift   <= '0;
      latched <= '0;
      last    <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (first || (bus.SSDInput != last)) begin
            shift   <= bus.SSDInput;
            latched <= bus.SSDInput;
            scratch <= '0;
            count   <= '0;
            busy_q  <= 1'b1;
            first   <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          {scratch, shift} <= {adj, shift} << 1;
          count            <= count + 4'd1;
          if (count == LAST_ITER) state <= DONE;
        end
        DONE: begin
          bcd_q  <= scratch;
          last   <= latched;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;
  logic [3:0]              anode_q;
  logic [6:0]              led_q;

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // NOTE: defaults are assigned before the case so every path writes every
  // output; a missing assignment in combinational logic infers a latch.
  always_comb begin
    digit = bcd_q[3:0];
    blank = 1'b0;
    case (sel)
      2'd0: digit = bcd_q[3:0];
      2'd1: begin
        digit = bcd_q[7:4];
        blank = BLANK_LZ && (bcd_q[15:4] == 12'd0);
      end
      2'd2: begin
        digit = bcd_q[11:8];
        blank = BLANK_LZ && (bcd_q[15:8] == 8'd0);
      end
      default: begin
        digit = bcd_q[15:12];
        blank = BLANK_LZ && (bcd_q[15:12] == 4'd0);
      end
    endcase
  end

  // Registered pins: the digit selected by the counter before the edge is
  // presented after it, so the first edge out of reset lights digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
      anode_q <= 4'b1111;
      led_q   <= 7'b1111111;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      anode_q <= ~(4'b0001 << sel);
      led_q   <= blank ? 7'b1111111 : seg7(digit);
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.busy    = busy_q;
  assign bus.Anode   = anode_q;
  assign bus.LED_out = led_q;

endmodule

// File: tb/tb_ssd_driver.sv
// tb_ssd_driver
//   Drives two ssd_driver instances (REFRESH_BITS=4; BLANK_LZ=1 and 0) with
//   the same input values and compares every output against a decimal-
//   arithmetic model of the value that should be committed and displayed.
module tb_ssd_driver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ssd_driver_if #(.IN_W(13)) bus_blank ();
  ssd_driver_if #(.IN_W(13)) bus_full ();

  ssd_driver #(.IN_W(13), .REFRESH_BITS(4), .BLANK_LZ(1'b1)) u_blank (
    .clk (clk),
    .rst (rst),
    .bus (bus_blank)
  );

  ssd_driver #(.IN_W(13), .REFRESH_BITS(4), .BLANK_LZ(1'b0)) u_full (
    .clk (clk),
    .rst (rst),
    .bus (bus_full)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: committed value and last converted value.
  int exp_val  = 0;
  int exp_last = 0;

  // Rising edges since reset release; the refresh counter before edge n is n-1.
  int unsigned edge_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic int digit_pos(int unsigned n);
    return int'(((n - 1) % 16) / 4);
  endfunction

  function automatic logic [3:0] exp_anode(int s);
    case (s)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(int v, int s, bit blank_lz);
    int p;
    int upper;
    p     = (s == 0) ? 1 : (s == 1) ? 10 : (s == 2) ? 100 : 1000;
    upper = v / p;
    if (blank_lz && s != 0 && upper == 0) return 7'b1111111;
    return seg_of(upper % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(int v);
    bus_blank.SSDInput = 13'(v);
    bus_full.SSDInput  = 13'(v);
  endtask

  // Compare all outputs of both instances with the model. 'shown' is the
  // value the display register was built from (bcd before the last edge).
  task automatic compare_to_model(string tag, logic exp_busy, int shown);
    int s;
    s = digit_pos(edge_cnt);
    n_checks++;
    if ({bus_blank.busy, bus_full.busy} !== {exp_busy, exp_busy}) begin
      n_fail++;
      $display("FAIL %s busy: got %b/%b expected %b", tag, bus_blank.busy, bus_full.busy, exp_busy);
    end
    n_checks++;
    if ({bus_blank.bcd, bus_full.bcd} !== {to_bcd(exp_val), to_bcd(exp_val)}) begin
      n_fail++;
      $display("FAIL %s bcd: got %h/%h expected %h", tag, bus_blank.bcd, bus_full.bcd, to_bcd(exp_val));
    end
    n_checks++;
    if ({bus_blank.Anode, bus_full.Anode} !== {exp_anode(s), exp_anode(s)}) begin
      n_fail++;
      $display("FAIL %s anode: got %b/%b expected %b", tag, bus_blank.Anode, bus_full.Anode, exp_anode(s));
    end
    n_checks++;
    if (bus_blank.LED_out !== exp_led(shown, s, 1'b1)) begin
      n_fail++;
      $display("FAIL %s led_blank digit%0d: got %b expected %b", tag, s, bus_blank.LED_out, exp_led(shown, s, 1'b1));
    end
    n_checks++;
    if (bus_full.LED_out !== exp_led(shown, s, 1'b0)) begin
      n_fail++;
      $display("FAIL %s led_full digit%0d: got %b expected %b", tag, s, bus_full.LED_out, exp_led(shown, s, 1'b0));
    end
  endtask

  // One clock; commit >= 0 means the model's bcd takes that value at this edge.
  task automatic step(string tag, logic exp_busy, int commit);
    int shown;
    tick();
    shown = exp_val;
    if (commit >= 0) exp_val = commit;
    compare_to_model(tag, exp_busy, shown);
  endtask

  task automatic check_in_reset(string tag);
    n_checks++;
    if ({bus_blank.Anode, bus_full.Anode, bus_blank.LED_out, bus_full.LED_out} !== {8'hFF, 14'h3FFF}) begin
      n_fail++;
      $display("FAIL %s pins: got %b %b %b %b expected 1111 1111 1111111 1111111", tag,
               bus_blank.Anode, bus_full.Anode, bus_blank.LED_out, bus_full.LED_out);
    end
    n_checks++;
    if ({bus_blank.bcd, bus_full.bcd, bus_blank.busy, bus_full.busy} !== 34'd0) begin
      n_fail++;
      $display("FAIL %s state: got bcd %h/%h busy %b/%b expected 0", tag,
               bus_blank.bcd, bus_full.bcd, bus_blank.busy, bus_full.busy);
    end
  endtask

  // Full conversion from an idle DUT: busy for 14 cycles, commit on the 15th edge.
  task automatic run_conversion(int v);
    drive(v);
    for (int k = 1; k <= 14; k++) step("conv", 1'b1, -1);
    step("commit", 1'b0, v);
    exp_last = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8191);
    #1;
    check_in_reset("reset");
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    exp_val  = 0;
    exp_last = 0;
    run_conversion(8191);
  endtask

  task automatic test_blank_zero();
    run_conversion(0);
    for (int k = 0; k < 16; k++) step("zero_display", 1'b0, -1);
  endtask

  task automatic test_change_mid_conv();
    drive(1234);
    for (int k = 1; k <= 5; k++) step("mid_a", 1'b1, -1);
    drive(42);
    for (int k = 6; k <= 14; k++) step("mid_a", 1'b1, -1);
    step("mid_commit_a", 1'b0, 1234);
    for (int k = 1; k <= 14; k++) step("mid_b", 1'b1, -1);
    step("mid_commit_b", 1'b0, 42);
    exp_last = 42;
  endtask

  task automatic test_blank_modes();
    run_conversion(1005);
    for (int k = 0; k < 16; k++) step("display_1005", 1'b0, -1);
  endtask

  task automatic test_reset_mid_conv();
    drive(4321);
    for (int k = 1; k <= 7; k++) step("abort_conv", 1'b1, -1);
    rst = 1'b1;
    #1;
    exp_val = 0;
    check_in_reset("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    run_conversion(4321);
  endtask

  task automatic test_stable();
    run_conversion(777);
    for (int k = 0; k < 1000; k++) step("stable", 1'b0, -1);
  endtask

  task automatic test_random();
    int vals[7] = '{8191, 0, 10, 100, 1000, 9, 8190};
    int v;
    for (int i = 0; i < 25; i++) begin
      v = (i < 7) ? vals[i] : int'($urandom_range(8191, 0));
      if (i == 20) v = exp_last;
      if (v == exp_last) begin
        drive(v);
        for (int k = 0; k < 20; k++) step("no_reconvert", 1'b0, -1);
      end else begin
        run_conversion(v);
        for (int k = 0; k < 8; k++) step("random_display", 1'b0, -1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blank_zero();
    test_change_mid_conv();
    test_blank_modes();
    test_reset_mid_conv();
    test_stable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
